// File: rtl/food_gen.sv
// Food placement: draws random grid cells, rejects off-board or snake-occupied
// ones via the occupancy tracker, and commits the first free cell found.
module food_gen #(
    parameter int X_BITS    = 5,
    parameter int Y_BITS    = 4,
    parameter int GRID_W    = 30,
    parameter int GRID_H    = 15,
    parameter int INIT_X    = 10,
    parameter int INIT_Y    = 7,
    parameter int MAX_TRIES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [8:0]        rand_num,
    input  logic              new_food_req,
    output logic              occ_req,
    output logic [X_BITS-1:0] occ_x,
    output logic [Y_BITS-1:0] occ_y,
    input  logic              occ_ack,
    input  logic              occ_hit,
    output logic [X_BITS-1:0] food_x,
    output logic [Y_BITS-1:0] food_y,
    output logic              food_valid,
    output logic              busy,
    output logic              food_fail
);

    typedef enum logic [1:0] {IDLE, SAMPLE, QUERY} state_t;

    localparam logic [7:0]        LAST_TRY = 8'(MAX_TRIES - 1);
    localparam logic [X_BITS-1:0] INIT_XV  = X_BITS'(INIT_X);
    localparam logic [Y_BITS-1:0] INIT_YV  = Y_BITS'(INIT_Y);

    state_t            state_q, state_d;
    logic [7:0]        tries_q, tries_d;
    logic              occ_req_d, food_valid_d, busy_d, food_fail_d;
    logic [X_BITS-1:0] occ_x_d, food_x_d;
    logic [Y_BITS-1:0] occ_y_d, food_y_d;
    logic [X_BITS-1:0] cx;
    logic [Y_BITS-1:0] cy;
    logic              in_range;
    logic              reject;

    assign cx       = rand_num[X_BITS-1:0];
    assign cy       = rand_num[X_BITS+Y_BITS-1:X_BITS];
    assign in_range = (int'(cx) < GRID_W) && (int'(cy) < GRID_H);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tries_q    <= '0;
            occ_req    <= 1'b0;
            occ_x      <= '0;
            occ_y      <= '0;
            food_x     <= INIT_XV;
            food_y     <= INIT_YV;
            food_valid <= 1'b1;
            busy       <= 1'b0;
            food_fail  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tries_q    <= tries_d;
            occ_req    <= occ_req_d;
            occ_x      <= occ_x_d;
            occ_y      <= occ_y_d;
            food_x     <= food_x_d;
            food_y     <= food_y_d;
            food_valid <= food_valid_d;
            busy       <= busy_d;
            food_fail  <= food_fail_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        occ_req_d    = occ_req;
        occ_x_d      = occ_x;
        occ_y_d      = occ_y;
        food_x_d     = food_x;
        food_y_d     = food_y;
        food_valid_d = food_valid;
        busy_d       = busy;
        food_fail_d  = food_fail;
        reject       = 1'b0;

        case (state_q)
            IDLE: begin
                if (new_food_req) begin
                    state_d      = SAMPLE;
                    food_valid_d = 1'b0;
                    busy_d       = 1'b1;
                    food_fail_d  = 1'b0;
                    tries_d      = '0;
                end
            end
            SAMPLE: begin
                if (!in_range) begin
                    reject = 1'b1;
                end else begin
                    occ_x_d   = cx;
                    occ_y_d   = cy;
                    occ_req_d = 1'b1;
                    state_d   = QUERY;
                end
            end
            QUERY: begin
                if (occ_ack) begin
                    occ_req_d = 1'b0;
                    if (occ_hit) begin
                        reject = 1'b1;
                    end else begin
                        food_x_d     = occ_x;
                        food_y_d     = occ_y;
                        food_valid_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Off-board and occupied candidates share one retry budget
        if (reject) begin
            if (tries_q == LAST_TRY) begin
                food_fail_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end else begin
                tries_d = tries_q + 8'd1;
                state_d = SAMPLE;
            end
        end
    end

endmodule

// File: tb/tb_food_gen.sv
// Scoreboard bench for food_gen: a timing-level placement model predicts queries
// and results; a negedge monitor checks them as the DUT produces them.
module tb_food_gen;

    localparam int SEQ_LEN = 20000;

    typedef struct {
        int delay;
        bit hit;
    } resp_t;

    typedef struct {
        logic [4:0] x;
        logic [3:0] y;
    } query_t;

    typedef struct {
        int         kind;
        int         edge_no;
        string      name;
        logic [4:0] fx;
        logic [3:0] fy;
        bit         valid;
        bit         busy;
        bit         fail;
        bit         req;
        int         nq;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] rand_num;
    logic       new_food_req;
    logic       occ_req;
    logic [4:0] occ_x;
    logic [3:0] occ_y;
    logic       occ_ack;
    logic       occ_hit;
    logic [4:0] food_x;
    logic [3:0] food_y;
    logic       food_valid;
    logic       busy;
    logic       food_fail;

    logic [8:0] seq [SEQ_LEN];
    resp_t      resp_q[$];
    query_t     exp_q[$];
    snap_t      snap_q[$];
    int         edge_n  = 0;
    bit         qmon_en = 1'b1;
    int         checks  = 0;
    int         failures = 0;
    logic [4:0] model_fx = 5'd10;
    logic [3:0] model_fy = 4'd7;

    always #5 clk = ~clk;

    food_gen dut (
        .clk(clk), .rst_n(rst_n), .rand_num(rand_num), .new_food_req(new_food_req),
        .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .busy(busy),
        .food_fail(food_fail)
    );

    // Free-running random source: the value sampled at edge k is seq[k-1]
    initial begin
        rand_num = '0;
        forever begin
            @(posedge clk);
            edge_n++;
            #1 rand_num = seq[edge_n];
        end
    end

    initial begin
        resp_t r;
        occ_ack = 1'b0;
        occ_hit = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (occ_req) begin
                if (resp_q.size() > 0) r = resp_q.pop_front();
                else begin r.delay = 0; r.hit = 1'b0; end
                repeat (r.delay) @(posedge clk);
                if (r.delay > 0) #2;
                occ_ack = 1'b1;
                occ_hit = r.hit;
                @(posedge clk);
                #2;
                occ_ack = 1'b0;
                occ_hit = 1'b0;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
        end
    endtask

    logic   prev_req  = 1'b0;
    logic   prev_busy = 1'b0;
    query_t cur_q;
    int     nq_seen = 0;

    initial begin
        snap_t s;
        forever begin
            @(negedge clk);
            if (qmon_en && occ_req) begin
                if (!prev_req) begin
                    nq_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL query_unexpected at edge %0d: got (%0d,%0d) expected none",
                                 edge_n, occ_x, occ_y);
                    end else begin
                        cur_q = exp_q.pop_front();
                        check_output("query_pos", 32'({occ_x, occ_y}), 32'({cur_q.x, cur_q.y}));
                    end
                end else begin
                    check_output("query_stable", 32'({occ_x, occ_y}), 32'({cur_q.x, cur_q.y}));
                end
            end
            while (snap_q.size() > 0 && snap_q[0].edge_no <= edge_n) begin
                s = snap_q.pop_front();
                if (s.kind == 0) begin
                    check_output(s.name,
                        32'({food_x, food_y, food_valid, busy, food_fail, occ_req}),
                        32'({s.fx, s.fy, s.valid, s.busy, s.fail, s.req}));
                end else if (s.kind == 1) begin
                    check_output(s.name,
                        32'({food_x, food_y, food_valid, busy, food_fail, occ_req, prev_busy, 8'(nq_seen)}),
                        32'({s.fx, s.fy, s.valid, 1'b0, s.fail, 1'b0, 1'b1, 8'(s.nq)}));
                    nq_seen = 0;
                end else begin
                    check_output("drain", 32'(exp_q.size()), 32'd0);
                end
            end
            prev_req  = occ_req;
            prev_busy = busy;
            if (edge_n > SEQ_LEN - 1000) begin
                checks++;
                failures++;
                $display("[TB] FAIL watchdog at edge %0d: got running expected finished", edge_n);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    // Walks a placement attempt by attempt from the rules: which candidates
    // get queried, when the answer lands, and what is finally committed.
    task automatic predict(input int t, input resp_t resps[64], output int done);
        int         s = t + 1;
        int         tries = 0;
        int         ri = 0;
        int         rej;
        logic [8:0] v;
        query_t     q;
        snap_t      r;
        r.kind = 1;
        r.name = "result";
        r.nq   = 0;
        r.busy = 1'b0;
        r.req  = 1'b0;
        forever begin
            v   = seq[s-1];
            q.x = v[4:0];
            q.y = v[8:5];
            if (q.x < 5'd30 && q.y < 4'd15) begin
                exp_q.push_back(q);
                r.nq++;
                rej = s + 1 + resps[ri].delay;
                if (!resps[ri].hit) begin
                    model_fx = q.x;
                    model_fy = q.y;
                    r.valid  = 1'b1;
                    r.fail   = 1'b0;
                    done     = rej;
                    break;
                end
                ri++;
            end else begin
                rej = s;
            end
            if (tries == 63) begin
                r.valid = 1'b0;
                r.fail  = 1'b1;
                done    = rej;
                break;
            end
            tries++;
            s = rej + 1;
        end
        r.fx      = model_fx;
        r.fy      = model_fy;
        r.edge_no = done;
        snap_q.push_back(r);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mode: 0 random, 1 clean, 2 off-board first, 3 slow occupied ack, 4 all occupied
    task automatic apply_stimulus(input int mode);
        resp_t resps[64];
        snap_t sn;
        int    t;
        int    done;
        wait_idle();
        resp_q.delete();
        for (int k = 0; k < 64; k++) begin
            resps[k].delay = (mode == 0 || mode == 4) ? $urandom_range(0, 3) : 0;
            resps[k].hit   = (mode == 4) || (mode == 0 && $urandom_range(0, 99) < 40);
        end
        if (mode == 3) begin
            resps[0].delay = 5;
            resps[0].hit   = 1'b1;
        end
        for (int k = 0; k < 64; k++) resp_q.push_back(resps[k]);
        t = edge_n + 1;
        if (mode == 1) seq[t] = 9'd132;
        if (mode == 2) begin
            seq[t] = 9'h1FF;
            for (int k = 1; k < 40; k++) seq[t+k] = 9'd132;
        end
        if (mode == 3) begin
            seq[t] = 9'd132;
            for (int k = 1; k < 40; k++) seq[t+k] = 9'd37;
        end
        if (mode == 4) begin
            for (int k = 0; k < 600; k++)
                seq[t+k] = {4'($urandom_range(0, 14)), 5'($urandom_range(0, 29))};
        end
        sn.kind = 0; sn.edge_no = t; sn.name = "req_accept";
        sn.fx = model_fx; sn.fy = model_fy;
        sn.valid = 1'b0; sn.busy = 1'b1; sn.fail = 1'b0; sn.req = 1'b0; sn.nq = 0;
        snap_q.push_back(sn);
        predict(t, resps, done);
        new_food_req = 1'b1;
        @(posedge clk);
        #1 new_food_req = 1'b0;
        if (mode == 3) begin
            repeat (2) @(posedge clk);
            #1 new_food_req = 1'b1;
            @(posedge clk);
            #1 new_food_req = 1'b0;
        end
        while (edge_n < done) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        snap_t sn;
        resp_t r;
        int    t;
        for (int i = 0; i < SEQ_LEN; i++) seq[i] = 9'($urandom_range(0, 511));
        rst_n        = 1'b0;
        new_food_req = 1'b0;
        sn.kind = 0; sn.fx = 5'd10; sn.fy = 4'd7; sn.valid = 1'b1; sn.busy = 1'b0;
        sn.fail = 1'b0; sn.req = 1'b0; sn.nq = 0;
        sn.edge_no = 2; sn.name = "reset";      snap_q.push_back(sn);
        sn.edge_no = 3; sn.name = "reset_hold"; snap_q.push_back(sn);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        apply_stimulus(1);
        apply_stimulus(2);
        apply_stimulus(3);
        for (int n = 0; n < 25; n++) apply_stimulus(0);
        apply_stimulus(4);
        apply_stimulus(0);

        // Reset while a query is outstanding; the late ack lands in IDLE
        wait_idle();
        resp_q.delete();
        r.delay = 12;
        r.hit   = 1'b0;
        resp_q.push_back(r);
        qmon_en = 1'b0;
        t = edge_n + 1;
        seq[t] = 9'd132;
        sn.kind = 0; sn.edge_no = t + 1; sn.name = "abort_query";
        sn.fx = model_fx; sn.fy = model_fy; sn.valid = 1'b0; sn.busy = 1'b1;
        sn.fail = 1'b0; sn.req = 1'b1;
        snap_q.push_back(sn);
        sn.fx = 5'd10; sn.fy = 4'd7; sn.valid = 1'b1; sn.busy = 1'b0; sn.req = 1'b0;
        sn.edge_no = t + 2;  sn.name = "abort_reset";    snap_q.push_back(sn);
        sn.edge_no = t + 16; sn.name = "abort_late_ack"; snap_q.push_back(sn);
        new_food_req = 1'b1;
        @(posedge clk);
        #1 new_food_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        while (edge_n < t + 16) begin
            @(posedge clk);
            #1;
        end
        model_fx = 5'd10;
        model_fy = 4'd7;
        qmon_en  = 1'b1;

        for (int n = 0; n < 5; n++) apply_stimulus(0);

        sn.kind = 2; sn.edge_no = edge_n + 2; sn.name = "drain";
        snap_q.push_back(sn);
        repeat (4) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
